hamming_tx_launcher: RTL and testbench
======================================

HAMMING_TX_LAUNCHER -- requirements
Module: hamming_tx_launcher

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), is the number of consecutive stable cycles required before the debounced button changes.
REQ-002 clk  input  1  sole clock (50 MHz system clock); all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_send  input  1  raw, asynchronous push-button that launches a message.
REQ-005 error_inject  input  1  raw switch; 1 enables error injection on the launched codeword.
REQ-006 message  input  4  raw switches carrying the data nibble to encode.
REQ-007 error_pos1  input  3  raw switches giving the first bit position to flip (0..6; 7 means none).
REQ-008 error_pos2  input  3  raw switches giving the second bit position to flip (0..6; 7 means none).
REQ-009 encoder_ready  input  1  the encoder accepts the payload in any cycle where tx_valid and encoder_ready are both 1.
REQ-010 tx_valid  output  1  payload valid to the encoder.
REQ-011 tx_message  output  4  captured data nibble.
REQ-012 tx_err_mask  output  7  captured channel error mask (bit i set means codeword bit i flips).
REQ-013 busy  output  1  state is not IDLE.
REQ-014 launch_count  output  8  number of completed transfers, wrapping modulo 256.

Function
REQ-015 Every raw input passes through a 2-flop synchronizer before use.
REQ-016 Debounce of synchronized btn_send:
- The counter clears on any cycle where the synchronized value equals the debounced value.
- Otherwise the counter increments.
- On reaching DEBOUNCE_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
REQ-017 Counter width is $clog2(DEBOUNCE_CYCLES+1); DEBOUNCE_CYCLES=1 makes the debounced value follow the synchronized value with one cycle delay.
REQ-018 A press event is a single-cycle pulse on the 0->1 transition of the debounced button.
REQ-019 FSM states are IDLE, SEND and WAIT_RELEASE; the reset state is IDLE.
REQ-020 IDLE -> SEND on a press event. In the same edge, tx_message takes the synchronized message and tx_err_mask takes the computed mask.
REQ-021 Mask rule:
- If synchronized error_inject is 0, the mask is 0.
- Otherwise the mask is onehot(pos1) OR onehot(pos2).
- A position of 7 contributes nothing.
- pos1 == pos2 yields a single set bit.
REQ-022 tx_valid is 1 exactly while the state is SEND, so tx_valid rises on the cycle after the press-event cycle.
REQ-023 While the state is SEND, tx_message and tx_err_mask stay constant regardless of switch changes.
REQ-024 SEND -> WAIT_RELEASE on the cycle where encoder_ready is 1. On that edge launch_count increments (255 wraps to 0), and tx_valid is 0 on the next cycle.
REQ-025 If encoder_ready is 1 on the first SEND cycle, the transfer completes in that cycle, giving a single-cycle tx_valid pulse.
REQ-026 WAIT_RELEASE -> IDLE when the debounced button is 0; no new launch is possible until the button is released and pressed again.
REQ-027 Press events outside IDLE are ignored.
REQ-028 Outside SEND, tx_message and tx_err_mask hold the last captured values.

Reset
REQ-029 Reset forces the following:
- state IDLE;
- tx_valid 0, busy 0;
- tx_message 0, tx_err_mask 0, launch_count 0;
- debounced button 0 and debounce counter 0;
- all synchronizer flops 0.
REQ-030 Reset asserted in SEND aborts the transfer: tx_valid is 0 on the cycle after reset is sampled and launch_count does not increment.
REQ-031 Reset has priority over every other event in the same cycle.

Structure
REQ-032 Package hamming_pkg holds the following:
- the launcher state enum;
- constant CODE_W=7 and constant DATA_W=4;
- the position-to-one-hot mask function.
REQ-033 A debounce sub-module named debounce (2-flop synchronizer, counter, stable output, rising-edge pulse) is instantiated once, for btn_send.

Verification
REQ-034 The bench uses DEBOUNCE_CYCLES=4.
REQ-035 Scenario 1, basic launch: message=4'hA, error_inject=0, encoder_ready=1, btn held for 20 cycles -> exactly one tx_valid pulse with tx_message=4'hA, tx_err_mask=7'h00, and launch_count=1.
REQ-036 Scenario 2, double error with stall: error_inject=1, pos1=2, pos2=5, encoder_ready=0 for 6 cycles then 1 -> tx_valid held for 7 cycles, tx_err_mask=7'b0100100 stable throughout, even though message toggles during the stall.
REQ-037 Scenario 3, positions: pos1=3, pos2=3 -> mask 7'b0001000; pos1=7, pos2=7 with inject=1 -> mask 7'h00.
REQ-038 Scenario 4, bounce: btn toggles every 2 cycles for 30 cycles then goes low -> no tx_valid; btn toggles then holds high -> exactly one launch.
REQ-039 Scenario 5, reset mid-SEND: reset pulsed while tx_valid=1 and encoder_ready=0 -> tx_valid=0 the next cycle, launch_count unchanged, and a later press launches normally.
REQ-040 Scenario 6, counter wrap: 256 complete press/release cycles -> launch_count returns to 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming transmit launcher.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitRelease
  } launch_state_e;

  // Positions at or beyond CODE_W (i.e. 7) select no bit.
  function automatic logic [CODE_W-1:0] pos_onehot(input logic [2:0] pos);
    logic [CODE_W-1:0] mask;
    mask = '0;
    if (32'(pos) < CODE_W) mask[pos] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, level and rising-edge pulse.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            db_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign level_o = db_q;
  assign rise_o  = db_q & ~db_prev_q;

endmodule

// File: rtl/hamming_tx_launcher.sv
// Captures a data nibble and channel error mask on a debounced button press and hands
// them to the encoder with a valid/ready handshake.
module hamming_tx_launcher
  import hamming_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_send,
  input  logic              error_inject,
  input  logic [DATA_W-1:0] message,
  input  logic [2:0]        error_pos1,
  input  logic [2:0]        error_pos2,
  input  logic              encoder_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_message,
  output logic [CODE_W-1:0] tx_err_mask,
  output logic              busy,
  output logic [7:0]        launch_count
);

  localparam int unsigned SwW = 1 + DATA_W + 3 + 3;

  logic [SwW-1:0] sw_meta_q, sw_sync_q;
  logic           sync_inject;
  logic [DATA_W-1:0] sync_msg;
  logic [2:0]     sync_pos1, sync_pos2;
  logic           btn_level, btn_rise;

  launch_state_e     state_q, state_d;
  logic [DATA_W-1:0] msg_q, msg_d;
  logic [CODE_W-1:0] mask_q, mask_d;
  logic [7:0]        count_q, count_d;
  logic [CODE_W-1:0] mask_calc;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_send),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  assign {sync_inject, sync_msg, sync_pos1, sync_pos2} = sw_sync_q;

  always_comb begin
    mask_calc = '0;
    if (sync_inject) mask_calc = pos_onehot(sync_pos1) | pos_onehot(sync_pos2);
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    mask_d  = mask_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (btn_rise) begin
          state_d = StSend;
          msg_d   = sync_msg;
          mask_d  = mask_calc;
        end
      end
      StSend: begin
        if (encoder_ready) begin
          state_d = StWaitRelease;
          count_d = count_q + 8'd1;
        end
      end
      StWaitRelease: begin
        if (!btn_level) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= StIdle;
      msg_q     <= '0;
      mask_q    <= '0;
      count_q   <= '0;
    end else begin
      sw_meta_q <= {error_inject, message, error_pos1, error_pos2};
      sw_sync_q <= sw_meta_q;
      state_q   <= state_d;
      msg_q     <= msg_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
    end
  end

  assign tx_valid     = (state_q == StSend);
  assign busy         = (state_q != StIdle);
  assign tx_message   = msg_q;
  assign tx_err_mask  = mask_q;
  assign launch_count = count_q;

endmodule

// File: tb/tb_hamming_tx_launcher.sv
// Scoreboard bench for hamming_tx_launcher: directed launches, masks, bounce, reset abort, wrap.
module tb_hamming_tx_launcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_send;
  logic       error_inject;
  logic [3:0] message;
  logic [2:0] error_pos1, error_pos2;
  logic       encoder_ready;
  logic       tx_valid;
  logic [3:0] tx_message;
  logic [6:0] tx_err_mask;
  logic       busy;
  logic [7:0] launch_count;

  int tests    = 0;
  int failures = 0;
  int valid_cycles = 0;

  logic [10:0] sb_q[$];   // {message, mask}

  hamming_tx_launcher #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_send     (btn_send),
    .error_inject (error_inject),
    .message      (message),
    .error_pos1   (error_pos1),
    .error_pos2   (error_pos2),
    .encoder_ready(encoder_ready),
    .tx_valid     (tx_valid),
    .tx_message   (tx_message),
    .tx_err_mask  (tx_err_mask),
    .busy         (busy),
    .launch_count (launch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int hold, input int rel);
    btn_send = 1'b1;
    tick(hold);
    btn_send = 1'b0;
    tick(rel);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 50; i++) begin
      if (tx_valid) break;
      tick(1);
    end
    if (i == 50) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every valid cycle must present the head of the scoreboard; pop on handshake.
  always @(negedge clk) begin
    if (!reset && tx_valid) begin
      valid_cycles++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("tx_message", 32'(tx_message), 32'(sb_q[0][10:7]));
        check("tx_err_mask", 32'(tx_err_mask), 32'(sb_q[0][6:0]));
        if (encoder_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    reset = 1'b1; btn_send = 1'b0; error_inject = 1'b0; message = 4'h0;
    error_pos1 = 3'd7; error_pos2 = 3'd7; encoder_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_message", 32'(tx_message), 32'd0);
    check("rst_tx_err_mask", 32'(tx_err_mask), 32'd0);
    check("rst_launch_count", 32'(launch_count), 32'd0);
    tick(2);

    // Scenario 1: basic launch, single-cycle pulse.
    message = 4'hA; error_inject = 1'b0; encoder_ready = 1'b1;
    sb_q.push_back({4'hA, 7'h00});
    v0 = valid_cycles;
    press_release(20, 12);
    check("s1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("s1_launch_count", 32'(launch_count), 32'd1);
    check("s1_idle", 32'(busy), 32'd0);

    // Scenario 2: double error held through a 6-cycle stall while message toggles.
    message = 4'h3; error_inject = 1'b1; error_pos1 = 3'd2; error_pos2 = 3'd5;
    encoder_ready = 1'b0;
    tick(3);
    sb_q.push_back({4'h3, 7'b0100100});
    v0 = valid_cycles;
    btn_send = 1'b1;
    wait_valid();
    for (int k = 0; k < 6; k++) begin
      message = message ^ 4'hF;
      tick(1);
    end
    encoder_ready = 1'b1;
    tick(1);
    check("s2_after_ready", 32'(tx_valid), 32'd0);
    btn_send = 1'b0;
    tick(12);
    check("s2_valid_cycles", 32'(valid_cycles - v0), 32'd7);
    check("s2_launch_count", 32'(launch_count), 32'd2);

    // Scenario 3: coincident and null positions.
    message = 4'h5; error_pos1 = 3'd3; error_pos2 = 3'd3;
    tick(3);
    sb_q.push_back({4'h5, 7'b0001000});
    press_release(20, 12);
    message = 4'h6; error_pos1 = 3'd7; error_pos2 = 3'd7;
    tick(3);
    sb_q.push_back({4'h6, 7'h00});
    press_release(20, 12);
    check("s3_launch_count", 32'(launch_count), 32'd4);

    // Scenario 4: bounce alone never launches; bounce then hold launches once.
    error_inject = 1'b0; message = 4'h9;
    v0 = valid_cycles;
    for (int k = 0; k < 15; k++) begin
      btn_send = ~btn_send;
      tick(2);
    end
    btn_send = 1'b0;
    tick(12);
    check("s4_bounce_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("s4_bounce_count", 32'(launch_count), 32'd4);
    sb_q.push_back({4'h9, 7'h00});
    for (int k = 0; k < 5; k++) begin
      btn_send = ~btn_send;
      tick(2);
    end
    press_release(20, 12);
    check("s4_hold_valid", 32'(valid_cycles - v0), 32'd1);
    check("s4_hold_count", 32'(launch_count), 32'd5);

    // Scenario 5: reset while stalled in SEND aborts the transfer.
    message = 4'hC; error_inject = 1'b1; error_pos1 = 3'd0; error_pos2 = 3'd6;
    encoder_ready = 1'b0;
    tick(3);
    sb_q.push_back({4'hC, 7'b1000001});
    btn_send = 1'b1;
    wait_valid();
    tick(2);
    check("s5_stalled_valid", 32'(tx_valid), 32'd1);
    btn_send = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("s5_abort_valid", 32'(tx_valid), 32'd0);
    check("s5_abort_busy", 32'(busy), 32'd0);
    // Reset clears the counter; the aborted transfer must not have added to it.
    check("s5_abort_count", 32'(launch_count), 32'd0);
    check("s5_abort_msg", 32'(tx_message), 32'd0);
    void'(sb_q.pop_front());
    tick(8);
    check("s5_still_idle", 32'(tx_valid), 32'd0);
    encoder_ready = 1'b1;
    tick(3);
    sb_q.push_back({4'hC, 7'b1000001});
    press_release(20, 12);
    check("s5_relaunch_count", 32'(launch_count), 32'd1);

    // Scenario 6: 256 launches wrap the counter.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    error_inject = 1'b0;
    for (int n = 0; n < 256; n++) begin
      message = 4'(n);
      tick(3);
      sb_q.push_back({4'(n), 7'h00});
      press_release(8, 10);
      if (n == 254) check("s6_count_255", 32'(launch_count), 32'd255);
    end
    check("s6_count_wrap", 32'(launch_count), 32'd0);

    tick(5);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
